// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: sizing helper, derived widths and read-mode codes.
// Used by the synchronous FIFO and by future clock-crossing variants.
package fifo_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int FIFO_DEF_DEPTH = 8;
  localparam int FIFO_ADDR_W    = clog2(FIFO_DEF_DEPTH);
  localparam int FIFO_CNT_W     = FIFO_ADDR_W + 1;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

endpackage

// File: rtl/fifo_mem_sdp.sv
// Simple dual-port RAM: synchronous write, combinational read.
// Contents are never reset.
module fifo_mem_sdp #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy, threshold flags,
// sticky error flags and selectable registered / fall-through read.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1,
  parameter int FWFT      = FIFO_STD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en_i,
  input  logic [DATA_W-1:0]       data_i,
  input  logic                    rd_en_i,
  output logic [DATA_W-1:0]       data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic                    almost_full_o,
  output logic                    almost_empty_o,
  output logic [clog2(DEPTH):0]   count_o,
  output logic                    overflow_o,
  output logic                    underflow_o,
  input  logic                    clr_err_i
);

  localparam int ADDR_W = clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [DATA_W-1:0] rdata, data_q;
  logic              rd_acc, wr_acc;
  logic              ovf_q, udf_q;

  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0])
                 & (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

  // Pointer distance mod 2^PTR_W is the occupancy
  assign count_o        = wr_ptr - rd_ptr;
  assign almost_full_o  = int'(count_o) >= AF_THRESH;
  assign almost_empty_o = int'(count_o) <= AE_THRESH;

  assign rd_acc = rd_en_i & ~empty_o;
  assign wr_acc = wr_en_i & (~full_o | rd_acc);

  fifo_mem_sdp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (data_i),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      data_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        data_q <= rdata;
      end
      if (wr_en_i & ~wr_acc) ovf_q <= 1'b1;
      else if (clr_err_i)    ovf_q <= 1'b0;
      if (rd_en_i & ~rd_acc) udf_q <= 1'b1;
      else if (clr_err_i)    udf_q <= 1'b0;
    end
  end

  assign overflow_o  = ovf_q;
  assign underflow_o = udf_q;

  // Fall-through shows the head directly; zero while empty
  assign data_o = (FWFT == FIFO_FWFT)
                ? (empty_o ? '0 : rdata)
                : data_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench: standard and fall-through FIFOs driven in lockstep
// and compared against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int DW = 8;
  localparam int DP = 8;

  logic          clk = 1'b0;
  logic          rst, wr_en, rd_en, clr;
  logic [DW-1:0] din;

  logic [DW-1:0] s_data, f_data;
  logic          s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic          f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [3:0]    s_count, f_count;

  int vecs = 0;
  int errs = 0;

  logic [DW-1:0] q[$];
  logic          m_ovf, m_udf;
  logic [DW-1:0] m_dstd;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .DATA_W(DW), .DEPTH(DP), .AF_THRESH(6), .AE_THRESH(1), .FWFT(0)
  ) u_std (
    .clk(clk), .rst(rst), .wr_en_i(wr_en), .data_i(din),
    .rd_en_i(rd_en), .data_o(s_data), .full_o(s_full),
    .empty_o(s_empty), .almost_full_o(s_af),
    .almost_empty_o(s_ae), .count_o(s_count),
    .overflow_o(s_ovf), .underflow_o(s_udf), .clr_err_i(clr)
  );

  sync_fifo_param #(
    .DATA_W(DW), .DEPTH(DP), .AF_THRESH(6), .AE_THRESH(1), .FWFT(1)
  ) u_fwft (
    .clk(clk), .rst(rst), .wr_en_i(wr_en), .data_i(din),
    .rd_en_i(rd_en), .data_o(f_data), .full_o(f_full),
    .empty_o(f_empty), .almost_full_o(f_af),
    .almost_empty_o(f_ae), .count_o(f_count),
    .overflow_o(f_ovf), .underflow_o(f_udf), .clr_err_i(clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("s_count", 32'(s_count), 32'(n));
    chk("s_empty", 32'(s_empty), 32'(n == 0));
    chk("s_full",  32'(s_full),  32'(n == DP));
    chk("s_af",    32'(s_af),    32'(n >= 6));
    chk("s_ae",    32'(s_ae),    32'(n <= 1));
    chk("s_ovf",   32'(s_ovf),   32'(m_ovf));
    chk("s_udf",   32'(s_udf),   32'(m_udf));
    chk("s_data",  32'(s_data),  32'(m_dstd));
    chk("f_count", 32'(f_count), 32'(n));
    chk("f_empty", 32'(f_empty), 32'(n == 0));
    chk("f_full",  32'(f_full),  32'(n == DP));
    chk("f_af",    32'(f_af),    32'(n >= 6));
    chk("f_ae",    32'(f_ae),    32'(n <= 1));
    chk("f_ovf",   32'(f_ovf),   32'(m_ovf));
    chk("f_udf",   32'(f_udf),   32'(m_udf));
    if (n > 0) chk("f_head", 32'(f_data), 32'(q[0]));
  endtask

  task automatic step(input logic w, input logic [DW-1:0] d,
                      input logic r, input logic c, input logic rs);
    logic racc, wacc;
    wr_en = w; din = d; rd_en = r; clr = c; rst = rs;
    @(posedge clk);
    if (rs) begin
      q.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_dstd = '0;
    end else begin
      racc = r && (q.size() > 0);
      wacc = w && ((q.size() < DP) || racc);
      if (racc) m_dstd = q.pop_front();
      if (wacc) q.push_back(d);
      if (w && !wacc) m_ovf = 1'b1;
      else if (c)     m_ovf = 1'b0;
      if (r && !racc) m_udf = 1'b1;
      else if (c)     m_udf = 1'b0;
    end
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0; din = '0;
    m_ovf = 1'b0; m_udf = 1'b0; m_dstd = '0;

    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);

    // fill then overflow
    for (int i = 1; i <= 8; i++) step(1, 8'(i), 0, 0, 0);
    step(1, 8'hFF, 0, 0, 0);

    // drain then underflow, then clear errors
    for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 1, 0);

    // wrap-around
    for (int i = 0; i < 5; i++) step(1, 8'(8'h10 + i), 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 8'(8'hA0 + i), 0, 0, 0);

    // simultaneous read/write while full
    for (int i = 0; i < 3; i++) step(1, 8'(8'hC0 + i), 1, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0, 0);

    // simultaneous read/write while empty
    step(1, 8'h33, 1, 0, 0);
    step(0, 8'h00, 1, 1, 0);

    // fall-through visibility
    step(1, 8'h5A, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);

    // reset mid-stream with a write pending
    for (int i = 0; i < 4; i++) step(1, 8'(8'h70 + i), 0, 0, 0);
    step(1, 8'hEE, 1, 0, 0);
    step(1, 8'hEE, 0, 0, 1);
    step(0, 8'h00, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 55,
           8'($urandom),
           $urandom_range(0, 99) < 45,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 249) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
